hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipelined RISC-V core (F/D/E/M/W).
//  Consumes register indices and decoded control bits per stage. Drives per-stage
//  stall/flush enables and EX-stage operand forwarding selects.
//  Also owns the data-memory wait handshake. A memory wait freezes the pipe; a memory
//  timeout is a sticky error.
// PARAMETERS
//  REG_AW       5   register index width
//  MEM_TIMEOUT  16  WAIT-state cycles tolerated before error (>=1)
// PORTS
//  clk          in   1       core clock, single domain
//  rst          in   1       asynchronous, active-high reset
//  rs1D, rs2D   in   REG_AW  source regs of instr in Decode
//  rs1E, rs2E   in   REG_AW  source regs of instr in Execute
//  rdE          in   REG_AW  dest reg in Execute
//  resultsrcE0  in   1       Execute instr is a load (resultsrc==01)
//  pcsrcE       in   1       taken branch / jal / jalr resolved in Execute
//  rdM, regwrM  in   REG_AW,1  Memory-stage dest reg / write enable
//  rdW, regwrW  in   REG_AW,1  Writeback-stage dest reg / write enable
//  memreqM      in   1       Memory-stage instr accesses data memory
//  memrdyM      in   1       data memory completes access this cycle
//  stallF/D/E/M out  1       hold F, D, E, M pipeline registers
//  flushD/E/W   out  1       clear D, E, W pipeline registers (insert bubble)
//  fwdAE, fwdBE out  2       EX operand select: 00 regfile, 01 W result, 10 M ALU result
//  mem_errM     out  1       sticky data-memory timeout flag
// BEHAVIOUR
//  - States: BOOT, IDLE, WAIT, ERR. BOOT is held while rst=1. The first clk edge after
//    release goes BOOT->IDLE.
//  - Outputs while rst=1 or in BOOT: all stalls 0, flushD/E/W 1, fwd 00, mem_errM 0.
//  - Forwarding (combinational, from IDLE/WAIT/ERR):
//    - fwdAE=10 if regwrM && rdM!=0 && rdM==rs1E.
//    - Else fwdAE=01 if regwrW && rdW!=0 && rdW==rs1E.
//    - Else 00. M has priority over W. fwdBE follows the same rule with rs2E.
//  - lwstall = resultsrcE0 && rdE!=0 && (rdE==rs1D || rdE==rs2D).
//  - memstall = (IDLE && memreqM && !memrdyM) || (WAIT && !memrdyM) || ERR.
//  - Priority, highest first:
//    - memstall: stallF/D/E/M=1, flushW=1, flushD/E=0. pcsrcE and lwstall are ignored;
//      they remain visible on the inputs and take effect once memstall clears.
//    - pcsrcE: flushD=1, flushE=1, stallF=stallD=0. A simultaneous lwstall is dropped,
//      because the load-use pair is squashed.
//    - lwstall: stallF=1, stallD=1, flushE=1. Exactly one bubble.
//    - Otherwise: all stalls and flushes 0.
//  - Memory FSM (registered, single wait counter cnt of width $clog2(MEM_TIMEOUT+1)):
//    - IDLE: memreqM && !memrdyM -> WAIT, cnt<=1. A zero-wait access (memrdyM=1 with
//      memreqM) stays in IDLE with no stall.
//    - WAIT: memrdyM -> IDLE. Else if cnt==MEM_TIMEOUT -> ERR. Else cnt<=cnt+1.
//    - ERR: stays until rst. mem_errM=1, pipe frozen.
//  - Timeout: MEM_TIMEOUT+1 stall cycles occur before ERR is entered.
//  - Reset mid-WAIT: asynchronously returns to BOOT, cnt cleared, mem_errM cleared.
//  - memreqM dropping while in WAIT is a protocol error. The FSM keeps waiting for
//    memrdyM; no recovery path.
//  - Register 0 is never forwarded or stall-checked.
// STRUCTURE
//  - riscv_pkg holds the shared constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10,
//    state encodings HZ_BOOT/HZ_IDLE/HZ_WAIT/HZ_ERR.
//  - Sub-module hz_mem_wait_fsm: state register, cnt, memstall, mem_errM.
//  - Top level: forwarding compare, lwstall detect, priority mux of stall/flush.
// TESTING
//  - Reset release: rst 1->0. First cycle: flushD/E/W=1, stalls 0. Next cycle all 0,
//    mem_errM=0.
//  - Forwarding:
//    - rs1E=5, rdM=5/regwrM=1, rdW=5/regwrW=1 -> fwdAE=10.
//    - rdM=0 instead -> fwdAE=01.
//    - rs2E=0 with rdW=0/regwrW=1 -> fwdBE=00.
//  - Load-use: resultsrcE0=1, rdE=7, rs2D=7 -> one cycle of stallF=stallD=flushE=1.
//    - Same cycle with pcsrcE=1 -> flushD=flushE=1, stallF=0.
//  - Memory wait:
//    - memreqM=1, memrdyM=0 for 3 cycles then 1 -> stallF..M=1 and flushW=1 for exactly
//      3 cycles, FSM back in IDLE, pcsrcE pending during wait then flushes D/E.
//  - Timeout: MEM_TIMEOUT=4, memreqM=1, memrdyM held 0:
//    - stalls high 5 cycles, mem_errM rises after 5th edge.
//    - Stays 1 even after memrdyM=1. Clears only on rst pulse.
//  - Reset mid-WAIT: assert rst in WAIT with cnt=2 -> outputs go to reset values
//    immediately, no clock needed.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants for the hazard/sequencing controller
// Purpose: EX operand forwarding select codes and memory-wait FSM state encodings.
// Contents: FWD_RF / FWD_WB / FWD_MEM select codes, hz_state_e state enum.
package riscv_pkg;

  // EX operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
  localparam logic [1:0] FWD_WB  = 2'b01;  // Writeback-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // Memory-stage ALU result

  // Data-memory wait FSM states
  typedef enum logic [1:0] {
    HZ_BOOT = 2'b00,
    HZ_IDLE = 2'b01,
    HZ_WAIT = 2'b10,
    HZ_ERR  = 2'b11
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups the per-stage register indices, control bits and the
// stall/flush/forward results exchanged between the core and hazard_ctrl.
// Modports:
//   master - pipeline side: drives indices/control, receives stall/flush/fwd/error
//   slave  - hazard_ctrl side: the reverse
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1D, rs2D;
  logic [REG_AW-1:0] rs1E, rs2E, rdE;
  logic              resultsrcE0;
  logic              pcsrcE;
  logic [REG_AW-1:0] rdM;
  logic              regwrM;
  logic [REG_AW-1:0] rdW;
  logic              regwrW;
  logic              memreqM;
  logic              memrdyM;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushW;
  logic [1:0]        fwdAE, fwdBE;
  logic              mem_errM;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, resultsrcE0, pcsrcE,
           rdM, regwrM, rdW, regwrW, memreqM, memrdyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           fwdAE, fwdBE, mem_errM
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, resultsrcE0, pcsrcE,
           rdM, regwrM, rdW, regwrW, memreqM, memrdyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           fwdAE, fwdBE, mem_errM
  );

endinterface

// File: rtl/hz_mem_wait_fsm.sv
// rtl/hz_mem_wait_fsm.sv - data-memory wait/timeout state machine
// Purpose: tracks outstanding data-memory accesses, raises memstall while the
// access is pending and latches a sticky timeout error.
// Ports:
//   clk, rst  in   clock, asynchronous active-high reset
//   memreqM   in   Memory-stage instr accesses data memory
//   memrdyM   in   data memory completes access this cycle
//   boot      out  FSM in BOOT (first cycle after reset release)
//   memstall  out  freeze the pipe this cycle
//   mem_errM  out  sticky timeout flag (registered)
module hz_mem_wait_fsm
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic memreqM,
  input  logic memrdyM,
  output logic boot,
  output logic memstall,
  output logic mem_errM
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HZ_BOOT;
      cnt      <= '0;
      mem_errM <= 1'b0;
    end else begin
      case (state)
        HZ_BOOT: state <= HZ_IDLE;
        HZ_IDLE: begin
          // Zero-wait accesses (memrdyM already high) never leave IDLE.
          if (memreqM && !memrdyM) begin
            state <= HZ_WAIT;
            cnt   <= CW'(1);
          end
        end
        HZ_WAIT: begin
          // memreqM is deliberately not looked at here: once waiting we only
          // leave on memrdyM or timeout.
          if (memrdyM) begin
            state <= HZ_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(MEM_TIMEOUT)) begin
            state    <= HZ_ERR;
            mem_errM <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HZ_ERR:  mem_errM <= 1'b1;
        default: state <= HZ_BOOT;
      endcase
    end
  end

  // The IDLE term makes the stall visible in the same cycle the access is
  // first presented, before the FSM has registered the WAIT state.
  assign memstall = ((state == HZ_IDLE) && memreqM && !memrdyM) ||
                    ((state == HZ_WAIT) && !memrdyM) ||
                    (state == HZ_ERR);

  assign boot = (state == HZ_BOOT);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard/sequencing controller for the 5-stage RISC-V pipe
// Purpose: EX-stage operand forwarding, load-use stall detection and the
// stall/flush priority mux, with the data-memory wait FSM as a sub-module.
// Ports:
//   clk, rst  in      core clock, asynchronous active-high reset
//   hz        slave   hazard_ctrl_if: register indices and control bits in,
//                     stallF/D/E/M, flushD/E/W, fwdAE/BE, mem_errM out
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_if.slave hz
);

  logic boot;
  logic memstall;
  logic lwstall;

  hz_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk      (clk),
    .rst      (rst),
    .memreqM  (hz.memreqM),
    .memrdyM  (hz.memrdyM),
    .boot     (boot),
    .memstall (memstall),
    .mem_errM (hz.mem_errM)
  );

  // Newest producer (M) wins over older (W); x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_w
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
      return FWD_MEM;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign lwstall = hz.resultsrcE0 && (hz.rdE != '0) &&
                   ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushW = 1'b0;
    hz.fwdAE  = FWD_RF;
    hz.fwdBE  = FWD_RF;
    if (boot) begin
      // Reset/BOOT: bubbles everywhere so stale pipeline contents never retire.
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushW = 1'b1;
    end else begin
      hz.fwdAE = fwd_sel(hz.rs1E, hz.rdM, hz.regwrM, hz.rdW, hz.regwrW);
      hz.fwdBE = fwd_sel(hz.rs2E, hz.rdM, hz.regwrM, hz.rdW, hz.regwrW);
      if (memstall) begin
        // Whole pipe frozen; W is bubbled so the M instruction retires only once.
        // Branch/load-use requests stay on the inputs and act after the freeze.
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end else if (hz.pcsrcE) begin
        // Redirect squashes D and E, which also kills any load-use pair.
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else if (lwstall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
      end
    end
  end

endmodule
